// File: rtl/vx_issue_scheduler_pkg.sv
// Shared constants for the warp issue scheduler and its arbiter.
package vx_issue_scheduler_pkg;

    // Default core configuration.
    localparam int NUM_WARPS_DEFAULT = 4;
    localparam int WARP_BITS         = $clog2(NUM_WARPS_DEFAULT);

    // Per-warp starvation counters are always 8 bits, so STARVE_LIMIT tops out at 255.
    localparam int STARVE_CNT_W = 8;

    // The pointer resets to the last warp so that the first rotation scan starts at warp 0.
    localparam logic [WARP_BITS-1:0] RR_PTR_RESET = WARP_BITS'(NUM_WARPS_DEFAULT - 1);

    // Reset value of the rotation pointer for an arbitrary warp count.
    function automatic int rr_ptr_reset_val(input int num_warps);
        return num_warps - 1;
    endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Combinational rotating find-first-set: scans ptr+1, ptr+2, ... (mod N)
// and returns the first requesting index.
module vx_rr_arbiter
    import vx_issue_scheduler_pkg::*;
#(
    parameter int N = NUM_WARPS_DEFAULT
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand_s;

    // Walk the request vector starting just after the pointer; N is a power of two,
    // so the index wraps by plain truncation (step N lands back on ptr itself).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_s      = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s = ptr + IW'(k);
            if (!grant_valid && req[cand_s]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_s;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/vx_issue_scheduler.sv
// Per-core warp issue scheduler: round-robin pick among hazard-free buffer heads,
// starvation override, one-entry valid/ready output register, and a
// scoreboard-stall performance counter.
module vx_issue_scheduler
    import vx_issue_scheduler_pkg::*;
#(
    parameter int NUM_WARPS    = NUM_WARPS_DEFAULT,
    parameter int STARVE_LIMIT = 15,
    parameter int CTR_W        = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WARPS-1:0]         warp_valid,
    input  logic [NUM_WARPS-1:0]         warp_blocked,
    output logic [NUM_WARPS-1:0]         warp_deq,
    output logic                         out_valid,
    output logic [$clog2(NUM_WARPS)-1:0] out_wid,
    output logic                         out_boost,
    input  logic                         out_ready,
    output logic [CTR_W-1:0]             perf_scb_stalls
);

    localparam int                       WID_W    = $clog2(NUM_WARPS);
    localparam logic [WID_W-1:0]         RR_RST_C = WID_W'(rr_ptr_reset_val(NUM_WARPS));
    localparam logic [STARVE_CNT_W-1:0]  LIMIT_C  = STARVE_CNT_W'(STARVE_LIMIT);

    logic [NUM_WARPS-1:0]    eligible_s;
    logic [NUM_WARPS-1:0]    starved_s;
    logic                    load_s;
    logic                    grant_s;
    logic                    boost_any_s;
    logic [WID_W-1:0]        boost_idx_s;
    logic                    rr_valid_s;
    logic [WID_W-1:0]        rr_idx_s;
    logic [WID_W-1:0]        sel_wid_s;
    logic [NUM_WARPS-1:0]    deq_s;

    logic                    out_valid_r;
    logic [WID_W-1:0]        out_wid_r;
    logic                    out_boost_r;
    logic [WID_W-1:0]        rr_ptr_r;
    logic [STARVE_CNT_W-1:0] starve_cnt_r [NUM_WARPS];
    logic [CTR_W-1:0]        perf_r;

    assign eligible_s = warp_valid & ~warp_blocked;
    assign load_s     = ~out_valid_r | out_ready;
    assign grant_s    = load_s & (|eligible_s);

    // Flag eligible warps whose starvation counter has reached the limit.
    always_comb begin
        starved_s = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            starved_s[i] = eligible_s[i] & (starve_cnt_r[i] == LIMIT_C);
        end
    end

    // Plain priority encoder for the starvation override: lowest starved index wins.
    always_comb begin
        boost_any_s = 1'b0;
        boost_idx_s = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!boost_any_s && starved_s[i]) begin
                boost_any_s = 1'b1;
                boost_idx_s = WID_W'(i);
            end else begin
                boost_any_s = boost_any_s;
            end
        end
    end

    vx_rr_arbiter #(
        .N (NUM_WARPS)
    ) u_rr_arbiter (
        .req         (eligible_s),
        .ptr         (rr_ptr_r),
        .grant_valid (rr_valid_s),
        .grant_idx   (rr_idx_s)
    );

    // The starvation override takes precedence over the rotation.
    always_comb begin
        if (boost_any_s) begin
            sel_wid_s = boost_idx_s;
        end else begin
            sel_wid_s = rr_idx_s;
        end
    end

    // One-hot pop strobe, only when the register captures the grant on this edge;
    // held low during reset so nothing is popped that cannot be captured.
    always_comb begin
        deq_s = '0;
        if (grant_s && rr_valid_s && !reset) begin
            deq_s = NUM_WARPS'(1) << sel_wid_s;
        end else begin
            deq_s = '0;
        end
    end

    assign warp_deq = deq_s;

    // Output register: load a new grant, drain when accepted with nothing to replace it,
    // otherwise hold every field under back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_wid_r   <= '0;
            out_boost_r <= 1'b0;
            rr_ptr_r    <= RR_RST_C;
        end else if (grant_s) begin
            out_valid_r <= 1'b1;
            out_wid_r   <= sel_wid_s;
            out_boost_r <= boost_any_s;
            rr_ptr_r    <= sel_wid_s;
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Starvation counters: clear on grant, count eligible-but-passed-over cycles
    // (including back-pressured ones), saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                starve_cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (grant_s && (sel_wid_s == WID_W'(i))) begin
                    starve_cnt_r[i] <= '0;
                end else if (eligible_s[i] && (starve_cnt_r[i] < LIMIT_C)) begin
                    starve_cnt_r[i] <= starve_cnt_r[i] + STARVE_CNT_W'(1);
                end else begin
                    starve_cnt_r[i] <= starve_cnt_r[i];
                end
            end
        end
    end

    // Count cycles where buffers have work but every head is waiting on the scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_r <= '0;
        end else if ((|warp_valid) && !(|eligible_s)) begin
            perf_r <= perf_r + CTR_W'(1);
        end else begin
            perf_r <= perf_r;
        end
    end

    assign out_valid       = out_valid_r;
    assign out_wid         = out_wid_r;
    assign out_boost       = out_boost_r;
    assign perf_scb_stalls = perf_r;

endmodule

// File: tb/tb_vx_issue_scheduler.sv
// Directed self-checking bench for vx_issue_scheduler. A second instance with
// STARVE_LIMIT=3 and a 3-bit counter covers the override and counter wrap.
module tb_vx_issue_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  warp_valid;
    logic [3:0]  warp_blocked;
    logic        out_ready;

    logic [3:0]  warp_deq;
    logic        out_valid;
    logic [1:0]  out_wid;
    logic        out_boost;
    logic [31:0] perf_scb_stalls;

    logic [3:0]  b_warp_deq;
    logic        b_out_valid;
    logic [1:0]  b_out_wid;
    logic        b_out_boost;
    logic [2:0]  b_perf;

    int checks;
    int errors;

    vx_issue_scheduler #(
        .NUM_WARPS    (4),
        .STARVE_LIMIT (15),
        .CTR_W        (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .warp_valid      (warp_valid),
        .warp_blocked    (warp_blocked),
        .warp_deq        (warp_deq),
        .out_valid       (out_valid),
        .out_wid         (out_wid),
        .out_boost       (out_boost),
        .out_ready       (out_ready),
        .perf_scb_stalls (perf_scb_stalls)
    );

    vx_issue_scheduler #(
        .NUM_WARPS    (4),
        .STARVE_LIMIT (3),
        .CTR_W        (3)
    ) dut_b (
        .clk             (clk),
        .reset           (reset),
        .warp_valid      (warp_valid),
        .warp_blocked    (warp_blocked),
        .warp_deq        (b_warp_deq),
        .out_valid       (b_out_valid),
        .out_wid         (b_out_wid),
        .out_boost       (b_out_boost),
        .out_ready       (out_ready),
        .perf_scb_stalls (b_perf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        warp_valid   = 4'hF;
        warp_blocked = 4'h0;
        out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_wid !== 2'd0) begin errors++; $display("FAIL reset_out_wid got %0d exp 0", out_wid); end
        checks++; if (out_boost !== 1'b0) begin errors++; $display("FAIL reset_out_boost got %b exp 0", out_boost); end
        checks++; if (perf_scb_stalls !== 32'd0) begin errors++; $display("FAIL reset_perf got %0d exp 0", perf_scb_stalls); end
        checks++; if (warp_deq !== 4'b0000) begin errors++; $display("FAIL reset_deq_forced got %b exp 0000", warp_deq); end
        warp_valid = 4'h0;
        reset      = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid got %b exp 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_w;
        warp_valid   = 4'hF;
        warp_blocked = 4'h0;
        out_ready    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_w = 2'(i);
            @(negedge clk);
            checks++; if (warp_deq !== (4'b0001 << exp_w)) begin errors++; $display("FAIL rr_deq[%0d] got %b exp %b", i, warp_deq, 4'b0001 << exp_w); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_wid !== exp_w) begin errors++; $display("FAIL rr_wid[%0d] got v=%b w=%0d exp v=1 w=%0d", i, out_valid, out_wid, exp_w); end
            checks++; if (out_boost !== 1'b0) begin errors++; $display("FAIL rr_boost[%0d] got %b exp 0", i, out_boost); end
        end
    endtask

    task automatic test_back_pressure();
        logic [3:0] pat [5];
        pat[0] = 4'hF; pat[1] = 4'h5; pat[2] = 4'hA; pat[3] = 4'hF; pat[4] = 4'h3;
        // Continue the rotation to warp 1 then warp 2.
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++; if (out_wid !== 2'(i)) begin errors++; $display("FAIL bp_pre_wid got %0d exp %0d", out_wid, i); end
        end
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            warp_valid = pat[k];
            @(negedge clk);
            checks++; if (warp_deq !== 4'b0000) begin errors++; $display("FAIL bp_deq[%0d] got %b exp 0000", k, warp_deq); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_wid !== 2'd2) begin errors++; $display("FAIL bp_hold[%0d] got v=%b w=%0d exp v=1 w=2", k, out_valid, out_wid); end
        end
        warp_valid = 4'hF;
        out_ready  = 1'b1;
        @(negedge clk);
        checks++; if (warp_deq !== 4'b1000) begin errors++; $display("FAIL bp_release_deq got %b exp 1000", warp_deq); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_wid !== 2'd3 || out_boost !== 1'b0) begin errors++; $display("FAIL bp_release got v=%b w=%0d b=%b exp v=1 w=3 b=0", out_valid, out_wid, out_boost); end
    endtask

    task automatic test_scb_stall();
        warp_valid   = 4'b0101;
        warp_blocked = 4'b0101;
        out_ready    = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++; if (warp_deq !== 4'b0000) begin errors++; $display("FAIL scb_deq[%0d] got %b exp 0000", k, warp_deq); end
            tick();
            checks++; if (perf_scb_stalls !== 32'(k)) begin errors++; $display("FAIL scb_perf[%0d] got %0d exp %0d", k, perf_scb_stalls, k); end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL scb_out_valid got %b exp 0", out_valid); end
        checks++; if (b_perf !== 3'd7) begin errors++; $display("FAIL scb_perf_narrow got %0d exp 7", b_perf); end
        repeat (2) tick();
        checks++; if (perf_scb_stalls !== 32'd9) begin errors++; $display("FAIL scb_perf_9 got %0d exp 9", perf_scb_stalls); end
        checks++; if (b_perf !== 3'd1) begin errors++; $display("FAIL scb_perf_wrap got %0d exp 1", b_perf); end
    endtask

    task automatic test_boost();
        reset        = 1'b1;
        warp_valid   = 4'h0;
        warp_blocked = 4'h0;
        out_ready    = 1'b0;
        tick();
        reset = 1'b0;
        // Warp 3 granted (warp 1 valid but blocked), pointer moves to 3.
        warp_valid   = 4'b1010;
        warp_blocked = 4'b0010;
        out_ready    = 1'b1;
        @(negedge clk);
        checks++; if (b_warp_deq !== 4'b1000) begin errors++; $display("FAIL boost_setup_deq got %b exp 1000", b_warp_deq); end
        tick();
        checks++; if (b_out_wid !== 2'd3 || b_out_valid !== 1'b1) begin errors++; $display("FAIL boost_setup_wid got v=%b w=%0d exp v=1 w=3", b_out_valid, b_out_wid); end
        // Warp 1 eligible but stuck behind back-pressure: its counter climbs to 3.
        warp_valid   = 4'b0010;
        warp_blocked = 4'b0000;
        out_ready    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (b_warp_deq !== 4'b0000) begin errors++; $display("FAIL boost_wait_deq[%0d] got %b exp 0000", k, b_warp_deq); end
            tick();
        end
        checks++; if (b_out_wid !== 2'd3) begin errors++; $display("FAIL boost_wait_wid got %0d exp 3", b_out_wid); end
        // Rotation from 3 would pick warp 0; the override picks warp 1.
        warp_valid = 4'b0011;
        out_ready  = 1'b1;
        @(negedge clk);
        checks++; if (b_warp_deq !== 4'b0010) begin errors++; $display("FAIL boost_deq got %b exp 0010", b_warp_deq); end
        tick();
        checks++; if (b_out_wid !== 2'd1 || b_out_boost !== 1'b1) begin errors++; $display("FAIL boost_grant got w=%0d b=%b exp w=1 b=1", b_out_wid, b_out_boost); end
        // Counter of warp 1 cleared: next pick is warp 0 by plain rotation.
        @(negedge clk);
        checks++; if (b_warp_deq !== 4'b0001) begin errors++; $display("FAIL boost_after_deq got %b exp 0001", b_warp_deq); end
        tick();
        checks++; if (b_out_wid !== 2'd0 || b_out_boost !== 1'b0) begin errors++; $display("FAIL boost_after got w=%0d b=%b exp w=0 b=0", b_out_wid, b_out_boost); end
    endtask

    task automatic test_reset_mid();
        warp_valid   = 4'hF;
        warp_blocked = 4'h0;
        out_ready    = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b exp 1", out_valid); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_wid !== 2'd0) begin errors++; $display("FAIL rmid_async got v=%b w=%0d exp v=0 w=0", out_valid, out_wid); end
        checks++; if (warp_deq !== 4'b0000) begin errors++; $display("FAIL rmid_deq got %b exp 0000", warp_deq); end
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (warp_deq !== 4'b0001) begin errors++; $display("FAIL rmid_first_deq got %b exp 0001", warp_deq); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_wid !== 2'd0 || out_boost !== 1'b0) begin errors++; $display("FAIL rmid_first got v=%b w=%0d b=%b exp v=1 w=0 b=0", out_valid, out_wid, out_boost); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        warp_valid   = 4'h0;
        warp_blocked = 4'h0;
        out_ready    = 1'b0;
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_scb_stall();
        test_boost();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
